// File: rtl/coordic_sincos.sv
// coordic_sincos: iterative 16-stage rotation-mode CORDIC, (mag, angle) -> (mag*cos, mag*sin).
// One micro-rotation per clock; angles are signed Q2.14 radians clamped to +/-pi/2.
// Optional feature macro: CORDIC_GAIN_COMP_EN pre-scales mag by K ~= 0.60725 so the
// outputs come out unity-gain; without it x0 = mag and the outputs carry the CORDIC
// gain (~1.6468), still saturated to the N-bit signed range.
module coordic_sincos #(
   parameter int unsigned N    = 16,
   parameter int unsigned ITER = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                st,
   input  logic signed [N-1:0] mag,
   input  logic signed [N-1:0] angle,
   output logic signed [N-1:0] x_out,
   output logic signed [N-1:0] y_out,
   output logic                busy,
   output logic                done,
   output logic                range_err
);

   localparam int unsigned W         = N + 2;
   localparam int unsigned CNT_W     = 4;
   localparam int          SAT_MAX_I = (2 ** (N - 1)) - 1;
   localparam int          ANG_LIM_I = 25736;

   localparam logic signed [W-1:0] SAT_MAX = W'(SAT_MAX_I);
   localparam logic signed [W-1:0] SAT_MIN = W'(-SAT_MAX_I - 1);
   localparam logic signed [N-1:0] ANG_MAX = N'(ANG_LIM_I);
   localparam logic signed [N-1:0] ANG_MIN = N'(-ANG_LIM_I);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      i_q, i_d;
   logic signed [W-1:0]   x_q, x_d;
   logic signed [W-1:0]   y_q, y_d;
   logic signed [W-1:0]   z_q, z_d;
   logic                  rerr_ld_q, rerr_ld_d;
   logic signed [N-1:0]   x_out_q, x_out_d;
   logic signed [N-1:0]   y_out_q, y_out_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  range_err_q, range_err_d;

   logic signed [W-1:0]   x0;
   logic signed [N-1:0]   ang_cl;
   logic                  ang_clamped;
   logic signed [W-1:0]   x_sh, y_sh, atan_v;
   logic signed [W-1:0]   x_rot, y_rot, z_rot;

   // Arctangent table, atan(2^-i) in Q2.14 (truncated).
   function automatic logic signed [W-1:0] atan_rom(input logic [CNT_W-1:0] idx);
      logic [15:0] v;
      case (idx)
         4'd0:    v = 16'h3243;
         4'd1:    v = 16'h1DAC;
         4'd2:    v = 16'h0FAD;
         4'd3:    v = 16'h07F5;
         4'd4:    v = 16'h03FE;
         4'd5:    v = 16'h01FF;
         4'd6:    v = 16'h00FF;
         4'd7:    v = 16'h007F;
         4'd8:    v = 16'h003F;
         4'd9:    v = 16'h001F;
         4'd10:   v = 16'h000F;
         4'd11:   v = 16'h0007;
         4'd12:   v = 16'h0003;
         4'd13:   v = 16'h0001;
         default: v = 16'h0000;
      endcase
      return W'(v);
   endfunction

   // Clip an internal value to the N-bit signed output range.
   function automatic logic signed [N-1:0] sat(input logic signed [W-1:0] v);
      logic signed [N-1:0] r;
      if (v > SAT_MAX) begin
         r = SAT_MAX[N-1:0];
      end else if (v < SAT_MIN) begin
         r = SAT_MIN[N-1:0];
      end else begin
         r = v[N-1:0];
      end
      return r;
   endfunction

   // Load-time operand preparation: angle clamp and initial x.
   always_comb begin
      ang_cl      = angle;
      ang_clamped = 1'b0;
      if (angle > ANG_MAX) begin
         ang_cl      = ANG_MAX;
         ang_clamped = 1'b1;
      end else if (angle < ANG_MIN) begin
         ang_cl      = ANG_MIN;
         ang_clamped = 1'b1;
      end
`ifdef CORDIC_GAIN_COMP_EN
      x0 = W'((32'(mag) * 32'sd9949) >>> 14);
`else
      x0 = W'(mag);
`endif
   end

   // One micro-rotation toward z = 0 using the current stage index.
   always_comb begin
      x_sh   = x_q >>> i_q;
      y_sh   = y_q >>> i_q;
      atan_v = atan_rom(i_q);
      if (z_q >= 0) begin
         x_rot = x_q - y_sh;
         y_rot = y_q + x_sh;
         z_rot = z_q - atan_v;
      end else begin
         x_rot = x_q + y_sh;
         y_rot = y_q - x_sh;
         z_rot = z_q + atan_v;
      end
   end

   // Next-state and output logic for IDLE -> ITER -> DONE sequencing.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      rerr_ld_d   = rerr_ld_q;
      x_out_d     = x_out_q;
      y_out_d     = y_out_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      range_err_d = range_err_q;
      case (state_q)
         S_IDLE: begin
            if (st) begin
               state_d   = S_ITER;
               busy_d    = 1'b1;
               i_d       = '0;
               x_d       = x0;
               y_d       = '0;
               z_d       = W'(ang_cl);
               rerr_ld_d = ang_clamped;
            end
         end
         S_ITER: begin
            x_d = x_rot;
            y_d = y_rot;
            z_d = z_rot;
            if (i_q == CNT_W'(ITER - 1)) begin
               state_d     = S_DONE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               i_d         = '0;
               x_out_d     = sat(x_rot);
               y_out_d     = sat(y_rot);
               range_err_d = rerr_ld_q;
            end else begin
               i_d = i_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         rerr_ld_q   <= 1'b0;
         x_out_q     <= '0;
         y_out_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         rerr_ld_q   <= rerr_ld_d;
         x_out_q     <= x_out_d;
         y_out_q     <= y_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         range_err_q <= range_err_d;
      end
   end

   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign range_err = range_err_q;

endmodule

// File: tb/tb_coordic_sincos.sv
// Scoreboard bench for coordic_sincos: the driver pushes a trig-based expectation
// per start, the monitor pops and checks on every done pulse.
module tb_coordic_sincos;

   localparam int unsigned N       = 16;
   localparam int unsigned ITER    = 16;
   localparam int          ANG_LIM = 25736;
`ifdef CORDIC_GAIN_COMP_EN
   localparam real GAIN = 1.0;
`else
   localparam real GAIN = 1.646760258;
`endif
   localparam real TOL_ABS = 32.0;

   typedef struct {
      int  done_cyc;
      real xe;
      real ye;
      real tol;
      bit  rerr;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic                st;
   logic signed [N-1:0] mag;
   logic signed [N-1:0] angle;
   logic signed [N-1:0] x_out;
   logic signed [N-1:0] y_out;
   logic                busy;
   logic                done;
   logic                range_err;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   exp_t e_mon;
   bit   btb = 1'b0;
   bit   prev_ok = 1'b0;
   int   prev_done = 0;

   coordic_sincos #(.N(N), .ITER(ITER)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st        (st),
      .mag       (mag),
      .angle     (angle),
      .x_out     (x_out),
      .y_out     (y_out),
      .busy      (busy),
      .done      (done),
      .range_err (range_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d..%0d", nm, cyc, act, lo, hi);
      end
   endtask

   // Compare one output axis against an ideal real value, window clipped to the rails.
   task automatic chk_axis(input string nm, input int act, input real ideal, input real tol);
      real lo_r, hi_r;
      lo_r = ideal - tol;
      hi_r = ideal + tol;
      if (lo_r > 32767.0)  lo_r = 32767.0;
      if (hi_r > 32767.0)  hi_r = 32767.0;
      if (lo_r < -32768.0) lo_r = -32768.0;
      if (hi_r < -32768.0) hi_r = -32768.0;
      chk(nm, act, int'($ceil(lo_r)), int'($floor(hi_r)));
   endtask

   // Reference: clamp the angle, then mag * gain * (cos, sin).
   task automatic push_exp(input int m, input int a);
      exp_t e;
      int   ac;
      real  th, amp;
      ac = (a > ANG_LIM) ? ANG_LIM : ((a < -ANG_LIM) ? -ANG_LIM : a);
      th = real'(ac) / 16384.0;
      amp = GAIN * real'(m);
      e.done_cyc = cyc + 1 + int'(ITER);
      e.xe   = amp * $cos(th);
      e.ye   = amp * $sin(th);
      e.tol  = TOL_ABS + amp / 800.0;
      e.rerr = (ac != a);
      exp_q.push_back(e);
   endtask

   // Wait for IDLE, present operands with st high, then scramble inputs while busy.
   task automatic start_op(input int m, input int a, input bit hold);
      int guard;
      guard = 0;
      @(negedge clk);
      while ((busy || done) && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) chk("idle_timeout", guard, 0, 39);
      st    = 1'b1;
      mag   = N'(m);
      angle = N'(a);
      push_exp(m, a);
      @(negedge clk);
      chk("busy_after_start", int'(busy), 1, 1);
      if (!hold) st = 1'b0;
      mag   = N'($urandom);
      angle = N'($urandom);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", int'(done), 0, 0);
         end else begin
            e_mon = exp_q.pop_front();
            chk("done_cycle", cyc, e_mon.done_cyc, e_mon.done_cyc);
            chk_axis("x_out", int'(x_out), e_mon.xe, e_mon.tol);
            chk_axis("y_out", int'(y_out), e_mon.ye, e_mon.tol);
            chk("range_err", int'(range_err), int'(e_mon.rerr), int'(e_mon.rerr));
            chk("busy_at_done", int'(busy), 0, 0);
            if (btb && prev_ok) chk("btb_spacing", cyc - prev_done, 18, 18);
            prev_done = cyc;
            prev_ok   = 1'b1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int dm[10];
      int da[10];
      int guard;
      dm = '{16384, 16384, 16384, 16384, 10000, 30000,     0, 32767,  5000, 32767};
      da = '{    0, 12867, -25736, 30000,     0,     0, 12000, 25736, -12867, -32768};

      rst_n = 1'b0;
      st    = 1'b0;
      mag   = '0;
      angle = '0;
      repeat (3) @(negedge clk);
      chk("rst_x_out", int'(x_out), 0, 0);
      chk("rst_y_out", int'(y_out), 0, 0);
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_done", int'(done), 0, 0);
      chk("rst_range_err", int'(range_err), 0, 0);
      rst_n = 1'b1;

      for (int k = 0; k < 10; k++) start_op(dm[k], da[k], 1'b0);

      // Abort an operation around iteration 5 and confirm everything clears.
      start_op(20000, 30000, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_x_out", int'(x_out), 0, 0);
      chk("abort_y_out", int'(y_out), 0, 0);
      chk("abort_busy", int'(busy), 0, 0);
      chk("abort_done", int'(done), 0, 0);
      chk("abort_range_err", int'(range_err), 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("abort_still_idle", int'(busy), 0, 0);

      for (int k = 0; k < 30; k++)
         start_op(int'($urandom_range(0, 32767)), int'($urandom_range(0, 60000)) - 30000, 1'b0);

      // st held high: back-to-back operations every 18 cycles.
      btb     = 1'b1;
      prev_ok = 1'b0;
      for (int k = 0; k < 6; k++)
         start_op(int'($urandom_range(0, 32767)), int'($urandom_range(0, 51472)) - 25736, 1'b1);
      st = 1'b0;

      guard = 0;
      while (exp_q.size() > 0 && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_outstanding", exp_q.size(), 0, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/coordic_sincos.md
# coordic_sincos

Iterative 16-stage CORDIC in rotation mode that converts polar input (magnitude, angle) into rectangular output (cos-scaled x, sin-scaled y). It is the inverse companion of the team's CORDIC vectoring block (arctan/magnitude): same Q2.14 angle format, same arctangent ROM, same `st`/done control style. It processes one micro-rotation per clock, sits on the same clock domain as the vectoring unit, and feeds the signal-generation and rotation datapaths.

## Interface
- `N`, 16: I/O data width; angle is signed Q2.14 radians.
- `ITER`, 16: number of micro-rotations; must be ≤ 16, the ROM depth.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `st`, input, 1: start request, sampled only in IDLE.
- `mag`, input, N: signed magnitude; valid range 0..32767.
- `angle`, input, N: signed Q2.14 angle; valid range ±25736 (±π/2).
- `x_out`, output, N: signed result, mag·cos(angle).
- `y_out`, output, N: signed result, mag·sin(angle).
- `busy`, output, 1: high while in ITER.
- `done`, output, 1: one-cycle pulse when results update.
- `range_err`, output, 1: angle was clamped; updates with `done`.

## Operation
- States:
  - IDLE: waits for `st`.
  - ITER: runs micro-rotations with counter i = 0..ITER-1.
  - DONE: one cycle, then back to IDLE.
- Load, at the IDLE edge where `st` = 1:
  - z0 = angle, clamped to ±25736. `range_err_next` = 1 if clamping occurred.
  - y0 = 0.
  - x0 = mag·K (see Configuration).
  - i = 0.
- Internal x, y, z are N+2 = 18-bit signed, to absorb CORDIC growth.
- Iteration, at each ITER edge, with d = +1 if z_i ≥ 0, else −1:
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·ATAN[i]
  - Shifts are arithmetic.
- ATAN ROM (Q2.14, indices 0..15): 0x3243, 0x1DAC, 0x0FAD, 0x07F5, 0x03FE, 0x01FF, 0x00FF, 0x007F, 0x003F, 0x001F, 0x000F, 0x0007, 0x0003, 0x0001, 0x0000, 0x0000.
- Output capture, on the edge where i = ITER−1 completes:
  - `x_out`/`y_out` ← final x/y, saturated to [−32768, 32767].
  - `range_err` ← the value latched at load.
- Outputs hold until the next capture.
- `st` is ignored in ITER and DONE; there is no queuing.
- `mag` and `angle` are sampled only at load; later changes have no effect.

## Timing
- Reset (async, `rst_n` low): state = IDLE, i = 0, internal regs = 0, `x_out` = `y_out` = 0, `busy` = `done` = `range_err` = 0.
- Reset asserted mid-operation aborts immediately. No `done` pulse follows. Outputs read 0.
- Edge E0 (IDLE, `st` = 1): load; `busy` rises after E0.
- Edges E1..E16: iterations i = 0..15. At E16, outputs are captured and state → DONE.
- `done` is high for exactly the cycle after E16. `busy` falls after E16.
- At E17, state → IDLE. If `st` = 1 at E18, the next load occurs.
- Minimum start-to-start spacing: 18 cycles.
- Latency from start edge to valid outputs is ITER cycles.
- `st` held high continuously gives back-to-back operations every 18 cycles.

## Configuration
- `CORDIC_GAIN_COMP_EN` defined:
  - x0 = (mag · 0x26DD) >>> 14, with K ≈ 0.60725 in Q2.14.
  - Outputs ≈ mag·cos and mag·sin, error ≤ ±8 LSB.
- `CORDIC_GAIN_COMP_EN` undefined:
  - x0 = mag; no multiplier is synthesized.
  - Outputs carry CORDIC gain ≈ 1.6468, i.e. ≈ 1.6468·mag·cos, with saturation still applied.
  - Latency is unchanged.

## Test plan
- With macro, mag = 16384, angle = 0 → `x_out` ≈ 16384 ±8, `y_out` ≈ 0 ±8; `done` pulses 16 cycles after the start edge; `range_err` = 0.
- With macro, mag = 16384, angle = 0x3243 (π/4) → `x_out` ≈ `y_out` ≈ 11585 ±8. Angle = −25736 → `x_out` ≈ 0 ±8, `y_out` ≈ −16384 ±8.
- Angle = 30000, mag = 16384 → clamped to +25736; `y_out` ≈ 16384 ±8; `range_err` = 1 during and after `done`.
- `rst_n` pulsed low at iteration 5 → `busy`/`done` = 0, outputs = 0, no `done` pulse. The next `st` completes normally with correct values.
- `st` held high throughout → `done` pulses every 18 cycles. Changing inputs while `busy` does not alter the in-flight result.
- Without macro, mag = 10000, angle = 0 → `x_out` ≈ 16468 ±8. Mag = 30000 → `x_out` saturates to 32767.
